// File: rtl/gba_dump_pkg.sv
// Shared constants and state encoding for the GBA pak dump command front-end.
package gba_dump_pkg;

    localparam int unsigned ADDR_W    = 24;
    localparam int unsigned ARG_BYTES = 6;

    // Command opcodes received over UART
    localparam logic [7:0] OP_READ   = 8'h52;
    localparam logic [7:0] OP_STATUS = 8'h53;

    // Single-byte replies sent back over UART
    localparam logic [7:0] RSP_ACK  = 8'h4B;
    localparam logic [7:0] RSP_NAK  = 8'h45;
    localparam logic [7:0] RSP_DONE = 8'h44;

    typedef enum logic [2:0] {
        IDLE,
        ARG,
        CHECK,
        SEND,
        LAUNCH,
        DUMP,
        DRAIN
    } schedState_e;

endpackage

// File: rtl/gba_dump_scheduler.sv
// Command parser, range checker, reader launcher and UART-TX owner.
// The scheduler sends its own reply bytes through SEND and hands the
// transmitter to the pak reader only while in DUMP.
module gba_dump_scheduler
    import gba_dump_pkg::*;
#(
    parameter int unsigned         TIMEOUT_CYCLES = 2700000,
    parameter logic [ADDR_W-1:0]   MAX_END        = 24'hFFFFFF
) (
    input  logic              pin_clk,
    input  logic              pin_rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [ADDR_W-1:0] rd_start_addr,
    output logic [ADDR_W-1:0] rd_end_addr,
    output logic              rd_start,
    input  logic              rd_done,
    input  logic [7:0]        rd_tx_data,
    input  logic              rd_tx_send,
    output logic              rd_tx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_send,
    input  logic              tx_ready,
    output logic              busy
);

    localparam int unsigned TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned ARG_W   = ADDR_W * 2;
    localparam int unsigned CMP_W   = ADDR_W + 1;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned GUARD_W = 2;

    schedState_e         state, stateNext;
    schedState_e         retState, retStateNext;
    logic [IDX_W-1:0]    argIdx, argIdxNext;
    logic [ARG_W-1:0]    argShift, argShiftNext;
    logic [TO_W-1:0]     toCnt, toCntNext;
    logic [GUARD_W-1:0]  guardCnt, guardCntNext;
    logic [7:0]          txByte, txByteNext;
    logic                txSendQ, txSendNext;
    logic                rdStartQ, rdStartNext;
    logic                busyQ, busyNext;
    logic [ADDR_W-1:0]   startAddr, startAddrNext;
    logic [ADDR_W-1:0]   endAddr, endAddrNext;
    logic [7:0]          dumpCount, dumpCountNext;

    logic [ADDR_W-1:0]   argStart;
    logic [ADDR_W-1:0]   argEnd;
    logic                rangeBad;

    // Decode the collected argument bytes: start first, end second, MSB first
    assign argStart = argShift[ARG_W-1:ADDR_W];
    assign argEnd   = argShift[ADDR_W-1:0];
    assign rangeBad = (argEnd < argStart) || (CMP_W'(argEnd) > CMP_W'(MAX_END));

    // TX is owned by the reader only during DUMP; otherwise reader strobes are dropped
    assign tx_data       = (state == DUMP) ? rd_tx_data : txByte;
    assign tx_send       = (state == DUMP) ? rd_tx_send : txSendQ;
    assign rd_tx_ready   = (state == DUMP) & tx_ready;
    assign rd_start      = rdStartQ;
    assign busy          = busyQ;
    assign rd_start_addr = startAddr;
    assign rd_end_addr   = endAddr;

    // State and datapath registers
    always_ff @(posedge pin_clk or negedge pin_rst_n) begin
        if (!pin_rst_n) begin
            state     <= IDLE;
            retState  <= IDLE;
            argIdx    <= '0;
            argShift  <= '0;
            toCnt     <= '0;
            guardCnt  <= '0;
            txByte    <= '0;
            txSendQ   <= 1'b0;
            rdStartQ  <= 1'b0;
            busyQ     <= 1'b0;
            startAddr <= '0;
            endAddr   <= '0;
            dumpCount <= '0;
        end else begin
            state     <= stateNext;
            retState  <= retStateNext;
            argIdx    <= argIdxNext;
            argShift  <= argShiftNext;
            toCnt     <= toCntNext;
            guardCnt  <= guardCntNext;
            txByte    <= txByteNext;
            txSendQ   <= txSendNext;
            rdStartQ  <= rdStartNext;
            busyQ     <= busyNext;
            startAddr <= startAddrNext;
            endAddr   <= endAddrNext;
            dumpCount <= dumpCountNext;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        stateNext     = state;
        retStateNext  = retState;
        argIdxNext    = argIdx;
        argShiftNext  = argShift;
        toCntNext     = toCnt;
        guardCntNext  = guardCnt;
        txByteNext    = txByte;
        txSendNext    = 1'b0;
        startAddrNext = startAddr;
        endAddrNext   = endAddr;
        dumpCountNext = dumpCount;

        case (state)
            IDLE: begin
                if (rx_valid) begin
                    if (rx_data == OP_READ) begin
                        stateNext  = ARG;
                        argIdxNext = '0;
                        toCntNext  = '0;
                    end else if (rx_data == OP_STATUS) begin
                        txByteNext   = dumpCount;
                        retStateNext = IDLE;
                        stateNext    = SEND;
                    end
                end
            end

            ARG: begin
                if (rx_valid) begin
                    argShiftNext = {argShift[ARG_W-9:0], rx_data};
                    toCntNext    = '0;
                    if (argIdx == IDX_W'(ARG_BYTES - 1)) begin
                        stateNext = CHECK;
                    end else begin
                        argIdxNext = argIdx + IDX_W'(1);
                    end
                end else if (toCnt >= TO_W'(TIMEOUT_CYCLES)) begin
                    stateNext = IDLE;
                end else begin
                    toCntNext = toCnt + TO_W'(1);
                end
            end

            CHECK: begin
                if (rangeBad) begin
                    txByteNext   = RSP_NAK;
                    retStateNext = IDLE;
                end else begin
                    startAddrNext = argStart;
                    endAddrNext   = argEnd;
                    txByteNext    = RSP_ACK;
                    retStateNext  = LAUNCH;
                end
                stateNext = SEND;
            end

            // guardCnt: 0 = waiting for ready, 3 = strobe cycle, 2..1 = guard cycles
            SEND: begin
                if (guardCnt == '0) begin
                    if (tx_ready) begin
                        txSendNext   = 1'b1;
                        guardCntNext = GUARD_W'(3);
                    end
                end else if (guardCnt == GUARD_W'(1)) begin
                    guardCntNext = '0;
                    stateNext    = retState;
                end else begin
                    guardCntNext = guardCnt - GUARD_W'(1);
                end
            end

            LAUNCH: begin
                stateNext = DUMP;
            end

            DUMP: begin
                if (rd_done) begin
                    stateNext = DRAIN;
                end
            end

            DRAIN: begin
                if (tx_ready) begin
                    dumpCountNext = dumpCount + 8'd1;
                    txByteNext    = RSP_DONE;
                    retStateNext  = IDLE;
                    stateNext     = SEND;
                end
            end

            default: begin
                stateNext = IDLE;
            end
        endcase

        rdStartNext = (stateNext == LAUNCH);
        busyNext    = (stateNext != IDLE);
    end

endmodule

// File: tb/tb_gba_dump_scheduler.sv
// Scoreboard bench for gba_dump_scheduler with a behavioural UART and pak reader.
module tb_gba_dump_scheduler;
    import gba_dump_pkg::*;

    localparam int unsigned TO = 100;

    logic        pin_clk = 1'b0;
    logic        pin_rst_n = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [23:0] rd_start_addr;
    logic [23:0] rd_end_addr;
    logic        rd_start;
    logic        rd_done = 1'b0;
    logic [7:0]  rd_tx_data = 8'h00;
    logic        rd_tx_send = 1'b0;
    logic        rd_tx_ready;
    logic [7:0]  tx_data;
    logic        tx_send;
    logic        tx_ready;
    logic        busy;

    logic        mainRxValid = 1'b0;
    logic [7:0]  mainRxData = 8'h00;
    logic        injValid = 1'b0;
    logic        killReader = 1'b0;
    logic        doneInject = 1'b0;

    int          nCompared = 0;
    int          nMismatched = 0;

    logic [7:0]  txQ[$];
    logic [47:0] launchQ[$];
    logic [7:0]  modelDump = 8'h00;
    logic [23:0] modelStart = 24'h0;
    logic [23:0] modelEnd = 24'h0;
    int unsigned uartCnt = 0;

    assign rx_valid = mainRxValid | injValid;
    assign rx_data  = injValid ? OP_STATUS : mainRxData;
    assign tx_ready = (uartCnt == 0);

    gba_dump_scheduler #(.TIMEOUT_CYCLES(TO), .MAX_END(24'hFFFFFF)) dut (
        .pin_clk(pin_clk), .pin_rst_n(pin_rst_n),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .rd_start_addr(rd_start_addr), .rd_end_addr(rd_end_addr),
        .rd_start(rd_start), .rd_done(rd_done),
        .rd_tx_data(rd_tx_data), .rd_tx_send(rd_tx_send), .rd_tx_ready(rd_tx_ready),
        .tx_data(tx_data), .tx_send(tx_send), .tx_ready(tx_ready),
        .busy(busy)
    );

    always #5 pin_clk = ~pin_clk;

    // UART transmitter model: busy for 6 cycles after each strobe
    always @(posedge pin_clk) begin
        if (tx_send === 1'b1) uartCnt <= 6;
        else if (uartCnt != 0) uartCnt <= uartCnt - 1;
    end

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare every TX byte and every launch against the scoreboard
    always @(negedge pin_clk) begin
        if (tx_send === 1'b1) begin
            if (txQ.size() == 0) begin
                nCompared++;
                nMismatched++;
                $display("FAIL unexpected_tx: got %h expected nothing", tx_data);
            end else begin
                check("tx_byte", 48'(tx_data), 48'(txQ.pop_front()));
            end
        end
        if (rd_start === 1'b1) begin
            if (launchQ.size() == 0) begin
                nCompared++;
                nMismatched++;
                $display("FAIL unexpected_launch: got %h/%h expected none", rd_start_addr, rd_end_addr);
            end else begin
                check("launch_addr", {rd_start_addr, rd_end_addr}, launchQ.pop_front());
            end
        end
    end

    // Pak reader model: emits a few random bytes, then pulses rd_done
    initial begin
        int n;
        int w;
        logic [7:0] b;
        forever begin
            @(negedge pin_clk);
            if (rd_start === 1'b1 && !killReader) begin
                n = $urandom_range(2, 5);
                for (int i = 0; i < n; i++) begin
                    w = 0;
                    while (rd_tx_ready !== 1'b1 && !killReader && w < 500) begin
                        @(negedge pin_clk);
                        w++;
                    end
                    if (killReader) break;
                    if (w >= 500) begin
                        check("reader_ready_timeout", 48'(w), 48'(0));
                        break;
                    end
                    @(posedge pin_clk); #1;
                    if (killReader) break;
                    b = 8'($urandom);
                    rd_tx_data = b;
                    rd_tx_send = 1'b1;
                    txQ.push_back(b);
                    @(posedge pin_clk); #1;
                    rd_tx_send = 1'b0;
                end
                rd_tx_send = 1'b0;
                if (!killReader) begin
                    @(posedge pin_clk); #1;
                    rd_done = 1'b1;
                    injValid = doneInject;
                    modelDump = modelDump + 8'd1;
                    txQ.push_back(RSP_DONE);
                    @(posedge pin_clk); #1;
                    rd_done = 1'b0;
                    injValid = 1'b0;
                end
            end
        end
    end

    task automatic sendByte(input logic [7:0] v);
        @(posedge pin_clk); #1;
        mainRxData = v;
        mainRxValid = 1'b1;
        @(posedge pin_clk); #1;
        mainRxValid = 1'b0;
    endtask

    // Reference: reject when end < start, otherwise ACK, launch, then DONE from reader
    task automatic sendRead(input logic [23:0] s, input logic [23:0] e);
        logic [47:0] args;
        if (e < s) begin
            txQ.push_back(RSP_NAK);
        end else begin
            txQ.push_back(RSP_ACK);
            launchQ.push_back({s, e});
            modelStart = s;
            modelEnd = e;
        end
        args = {s, e};
        sendByte(OP_READ);
        for (int i = 5; i >= 0; i--) begin
            repeat ($urandom_range(0, 3)) @(posedge pin_clk);
            sendByte(args[i*8 +: 8]);
        end
    endtask

    task automatic sendStatus();
        txQ.push_back(modelDump);
        sendByte(OP_STATUS);
    endtask

    task automatic waitIdle(input string name);
        int w;
        repeat (3) @(negedge pin_clk);
        w = 0;
        while (busy !== 1'b0 && w < 3000) begin
            @(negedge pin_clk);
            w++;
        end
        check(name, 48'(busy), 48'(1'b0));
        check("tx_drained", 48'(txQ.size()), 48'(0));
    endtask

    task automatic waitLaunch();
        int w;
        w = 0;
        while (rd_start !== 1'b1 && w < 500) begin
            @(negedge pin_clk);
            w++;
        end
        check("launch_seen", 48'(rd_start), 48'(1'b1));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [23:0] s;
        logic [23:0] e;
        logic [7:0]  j;
        int          w;

        repeat (3) @(negedge pin_clk);
        check("rst_tx_send", 48'(tx_send), 48'(1'b0));
        check("rst_tx_data", 48'(tx_data), 48'(8'h00));
        check("rst_rd_start", 48'(rd_start), 48'(1'b0));
        check("rst_busy", 48'(busy), 48'(1'b0));
        check("rst_rd_tx_ready", 48'(rd_tx_ready), 48'(1'b0));
        check("rst_addrs", {rd_start_addr, rd_end_addr}, 48'(0));
        @(posedge pin_clk); #1;
        pin_rst_n = 1'b1;

        // Partial command abandoned by timeout, then status
        sendByte(OP_READ);
        sendByte(8'h00);
        sendByte(8'h00);
        repeat (TO + 10) @(negedge pin_clk);
        check("timeout_idle", 48'(busy), 48'(1'b0));
        sendStatus();
        waitIdle("status_after_timeout");

        // Directed accept, reject, zero-length
        sendRead(24'h000000, 24'h00005F);
        waitIdle("dump_basic");
        sendRead(24'h000100, 24'h0000FF);
        waitIdle("reject");
        check("addr_after_reject", {rd_start_addr, rd_end_addr}, {modelStart, modelEnd});
        sendRead(24'h001234, 24'h001234);
        waitIdle("zero_length");

        // Junk byte ignored, then status after two dumps
        sendByte(8'h61);
        repeat (4) @(negedge pin_clk);
        check("junk_busy", 48'(busy), 48'(1'b0));
        sendStatus();
        waitIdle("status_two");

        // Randomized command mix
        for (int k = 0; k < 16; k++) begin
            case ($urandom_range(0, 3))
                0: begin
                    s = 24'($urandom);
                    e = s + 24'($urandom_range(0, 64));
                    sendRead(s, e);
                end
                1: begin
                    s = 24'($urandom_range(1, 24'hFFFFFF));
                    e = s - 24'($urandom_range(1, 32'(s)));
                    sendRead(s, e);
                end
                2: sendStatus();
                default: begin
                    j = 8'($urandom);
                    if (j == OP_READ || j == OP_STATUS) j = 8'h00;
                    sendByte(j);
                end
            endcase
            waitIdle("random_cmd");
        end
        check("addr_after_random", {rd_start_addr, rd_end_addr}, {modelStart, modelEnd});

        // Commands injected during DUMP and alongside rd_done are dropped
        doneInject = 1'b1;
        sendRead(24'h000200, 24'h000300);
        waitLaunch();
        sendByte(OP_STATUS);
        sendByte(OP_READ);
        waitIdle("inject_dump");
        doneInject = 1'b0;
        check("addr_after_inject", {rd_start_addr, rd_end_addr}, {modelStart, modelEnd});

        // Asynchronous reset in the middle of a dump
        sendRead(24'h000040, 24'h000080);
        waitLaunch();
        w = 0;
        while (rd_tx_ready !== 1'b1 && w < 500) begin
            @(negedge pin_clk);
            w++;
        end
        check("dump_ready_seen", 48'(rd_tx_ready), 48'(1'b1));
        #2;
        killReader = 1'b1;
        pin_rst_n = 1'b0;
        #1;
        check("arst_tx_send", 48'(tx_send), 48'(1'b0));
        check("arst_rd_tx_ready", 48'(rd_tx_ready), 48'(1'b0));
        check("arst_busy", 48'(busy), 48'(1'b0));
        check("arst_addrs", {rd_start_addr, rd_end_addr}, 48'(0));
        repeat (20) @(negedge pin_clk);
        txQ.delete();
        launchQ.delete();
        modelDump = 8'h00;
        modelStart = 24'h0;
        modelEnd = 24'h0;
        killReader = 1'b0;
        @(posedge pin_clk); #1;
        pin_rst_n = 1'b1;

        sendRead(24'h000000, 24'h000010);
        waitIdle("dump_after_reset");
        sendStatus();
        waitIdle("status_after_reset");

        check("launch_q_empty", 48'(launchQ.size()), 48'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
